accum_avl_slave: RTL
====================

// Module: accum_avl_slave
// PURPOSE
// Avalon-MM responder (slave) peripheral answering the Nios II data master in the lab SoC.
// Moves the switch/key/LED accumulator function from software PIO polling into fabric.
// Debounces the accumulate and clear keys and sums the switch value into an 8-bit accumulator.
// Exposes registers to software and drives the green LEDs directly.
// PARAMETERS
// DEBOUNCE_CYCLES  500000  stable cycles before a key level is accepted (10 ms @ 50 MHz); min 2
// ACC_W            8       accumulator width; equals SW width and LEDG width
// PORTS
// Clk             in   1      system clock (CLOCK_50 domain)
// Reset_n         in   1      asynchronous active-low reset
// AVL_CS          in   1      chip select
// AVL_READ        in   1      read strobe, valid only with AVL_CS
// AVL_WRITE       in   1      write strobe, valid only with AVL_CS
// AVL_ADDR        in   2      word address of register
// AVL_WRITEDATA   in   32     write data
// AVL_READDATA    out  32     read data, fixed read latency 1
// SW_IN           in   ACC_W  raw switches, asynchronous
// KEY_ACC_n       in   1      raw accumulate key, active-low, asynchronous
// KEY_CLR_n       in   1      raw clear key, active-low, asynchronous
// LED_OUT         out  ACC_W  accumulator value to LEDG
// IRQ             out  1      level interrupt to Nios
// BEHAVIOUR
// - Reset (async assert, sync release): acc=0, OVF=0, EDGE=0, CTRL=0, AVL_READDATA=0, LED_OUT=0, IRQ=0;
//   debouncers reset to released (level 1), counters 0, synchronisers to 1 (keys) / 0 (SW).
// - SW_IN, KEY_*_n pass through 2-FF synchronisers; 2-cycle latency.
// - Debounce per key: counter clears when synced level == accepted level, else increments;
//   at DEBOUNCE_CYCLES-1 accepted level flips, counter clears. Press = accepted 1->0, one-cycle pulse.
// - Register map (32-bit, unused bits read 0):
//   0 SW     RO   {24'b0, sw_sync}
//   1 ACC    RW   {23'b0, OVF, acc}; write loads acc=WD[7:0], OVF=WD[8]
//   2 EDGE   R/W1C bit0 acc-press seen, bit1 clr-press seen; write 1 clears bit
//   3 CTRL   RW   bit0 HW_ACC_EN, bit1 IRQ_EN
// - Acc press with HW_ACC_EN=1: {carry,acc} = acc + sw_sync (9-bit add); acc wraps mod 256;
//   carry=1 sets OVF (sticky). HW_ACC_EN=0: only EDGE bit0 sets.
// - Clr press: acc=0, OVF=0 regardless of HW_ACC_EN; EDGE bit1 sets.
// - Same-cycle priority on acc/OVF: bus write to ACC > clr press > acc press.
// - EDGE: hardware set and W1C in same cycle -> bit stays set.
// - Read: AVL_CS&AVL_READ in cycle N -> AVL_READDATA valid cycle N+1, held until next read.
//   Read returns register state sampled at cycle N (pre-update). No wait-states.
// - Write: AVL_CS&AVL_WRITE takes effect at end of cycle; READ and WRITE together -> WRITE ignored.
// - Strobes without AVL_CS ignored; addresses fully decoded, no side effects on read.
// - LED_OUT = acc, registered, same cycle as acc update.
// - Reset_n asserted mid-debounce or mid-read: all state to reset values immediately; no pending read
//   completes.
// CONFIGURATION
// - ACCUM_IRQ_EN defined: IRQ = IRQ_EN & (EDGE[0] | EDGE[1]), registered (1 cycle after EDGE change);
//   cleared by W1C of EDGE bits or IRQ_EN=0.
// - ACCUM_IRQ_EN undefined: IRQ tied 0; CTRL bit1 not stored, reads 0; EDGE still works (polling).
// TESTING (DEBOUNCE_CYCLES=4)
// 1 Reset: Reset_n=0 mid-run -> all outputs 0 immediately; read addr0 after release with SW=0x5A -> 0x5A.
// 2 HW_ACC_EN=1, SW=0x30, three clean acc presses -> ACC reads 0x090, LED_OUT=0x90, EDGE=0x1.
// 3 acc=0xF0, SW=0x20, acc press -> ACC reads 0x110 (acc 0x10, OVF 1); clr press -> 0x000, EDGE=0x3.
// 4 Bounce: KEY_ACC_n glitches low 3 cycles then high -> no press, acc unchanged; held low 6 cycles -> 1 press.
// 5 Bus write ACC=0x07 same cycle as acc press -> ACC=0x007; EDGE bit0 set; W1C same cycle as new press -> bit stays 1.
// 6 ACCUM_IRQ_EN: IRQ_EN=1, clr press -> IRQ=1 next cycle; write EDGE=0x2 -> IRQ=0; undefined -> IRQ stays 0.

Source files
------------

// File: rtl/accum_avl_slave.sv
// ---------------------------------------------------------------------------
// accum_avl_slave
//   Avalon-MM responder for the Nios II data master. It debounces the
//   accumulate and clear keys, adds the switch value into an accumulator on
//   each accumulate press, exposes the state as four 32-bit registers and
//   drives the green LEDs directly.
//
//   Optional feature macro: ACCUM_IRQ_EN
//     defined   -> CTRL bit1 (IRQ_EN) is stored and IRQ is a registered level
//                  interrupt: IRQ_EN & (EDGE[0] | EDGE[1]).
//     undefined -> IRQ tied low, CTRL bit1 reads 0; EDGE is still usable by
//                  polling.
//
//   Register map (word addresses, unused bits read 0)
//     0 SW    RO     {0, sw_sync}
//     1 ACC   RW     {0, OVF, acc}
//     2 EDGE  R/W1C  bit0 accumulate press seen, bit1 clear press seen
//     3 CTRL  RW     bit0 HW_ACC_EN, bit1 IRQ_EN
//
//   Ports
//     Clk, Reset_n        clock, asynchronous active-low reset
//     AVL_CS/READ/WRITE   Avalon chip select and strobes
//     AVL_ADDR            register word address
//     AVL_WRITEDATA       write data
//     AVL_READDATA        read data, fixed latency 1, held between reads
//     SW_IN               raw switches (asynchronous)
//     KEY_ACC_n/KEY_CLR_n raw active-low keys (asynchronous)
//     LED_OUT             accumulator value
//     IRQ                 level interrupt
// ---------------------------------------------------------------------------

// Key conditioner: 2-FF synchroniser followed by a level debouncer.
// press pulses for one cycle when the accepted level falls from 1 to 0.
module accum_avl_slave_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic raw,
    output logic press
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic             level;
    logic [CNT_W-1:0] cnt;
    logic             flip;

    assign flip  = (sync_2 != level) && (cnt == CNT_MAX);
    assign press = flip && !sync_2;

    // NOTE: every flop gets its reset value here; keys idle released (1).
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            level  <= 1'b1;
            cnt    <= '0;
        end else begin
            // NOTE: non-blocking assignments so sync_2 takes the old sync_1.
            sync_1 <= raw;
            sync_2 <= sync_1;
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (flip) begin
                level <= sync_2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module accum_avl_slave #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACC_W           = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             AVL_CS,
    input  logic             AVL_READ,
    input  logic             AVL_WRITE,
    input  logic [1:0]       AVL_ADDR,
    input  logic [31:0]      AVL_WRITEDATA,
    output logic [31:0]      AVL_READDATA,
    input  logic [ACC_W-1:0] SW_IN,
    input  logic             KEY_ACC_n,
    input  logic             KEY_CLR_n,
    output logic [ACC_W-1:0] LED_OUT,
    output logic             IRQ
);
    typedef enum logic [1:0] {
        ADDR_SW   = 2'd0,
        ADDR_ACC  = 2'd1,
        ADDR_EDGE = 2'd2,
        ADDR_CTRL = 2'd3
    } reg_addr_t;

    logic [ACC_W-1:0] sw_sync_1;
    logic [ACC_W-1:0] sw_sync;
    logic             acc_press;
    logic             clr_press;

    logic [ACC_W-1:0] acc,   acc_next;
    logic             ovf,   ovf_next;
    logic [1:0]       edge_q, edge_next;
    logic             acc_en;
    logic             irq_en;
    logic [ACC_W:0]   sum;

    logic             rd;
    logic             wr;
    reg_addr_t        addr;
    logic [31:0]      rd_mux;

    // Bits of write data no register uses.
    logic             unused_wd;
    assign unused_wd = &{1'b0, AVL_WRITEDATA[31:ACC_W+1]};

    assign addr = reg_addr_t'(AVL_ADDR);
    assign rd   = AVL_CS && AVL_READ;
    // A simultaneous read and write is treated as a read only.
    assign wr   = AVL_CS && AVL_WRITE && !AVL_READ;

    accum_avl_slave_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_acc (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .raw     (KEY_ACC_n),
        .press   (acc_press)
    );

    accum_avl_slave_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .raw     (KEY_CLR_n),
        .press   (clr_press)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sw_sync_1 <= '0;
            sw_sync   <= '0;
        end else begin
            sw_sync_1 <= SW_IN;
            sw_sync   <= sw_sync_1;
        end
    end

    assign sum = {1'b0, acc} + {1'b0, sw_sync};

    // Accumulator priority: bus write > clear press > accumulate press.
    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        acc_next = acc;
        ovf_next = ovf;
        if (wr && addr == ADDR_ACC) begin
            acc_next = AVL_WRITEDATA[ACC_W-1:0];
            ovf_next = AVL_WRITEDATA[ACC_W];
        end else if (clr_press) begin
            acc_next = '0;
            ovf_next = 1'b0;
        end else if (acc_press && acc_en) begin
            acc_next = sum[ACC_W-1:0];
            ovf_next = ovf | sum[ACC_W];
        end
    end

    // A hardware set in the same cycle as a W1C wins.
    always_comb begin
        edge_next = edge_q;
        if (wr && addr == ADDR_EDGE) begin
            edge_next = edge_q & ~AVL_WRITEDATA[1:0];
        end
        edge_next = edge_next | {clr_press, acc_press};
    end

    // Read mux samples the current (pre-update) register state.
    always_comb begin
        rd_mux = '0;
        unique case (addr)
            ADDR_SW:   rd_mux = 32'(sw_sync);
            ADDR_ACC:  rd_mux = 32'({ovf, acc});
            ADDR_EDGE: rd_mux = 32'(edge_q);
            ADDR_CTRL: rd_mux = 32'({irq_en, acc_en});
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            acc          <= '0;
            ovf          <= 1'b0;
            edge_q       <= '0;
            acc_en       <= 1'b0;
            AVL_READDATA <= '0;
        end else begin
            acc    <= acc_next;
            ovf    <= ovf_next;
            edge_q <= edge_next;
            if (wr && addr == ADDR_CTRL) begin
                acc_en <= AVL_WRITEDATA[0];
            end
            if (rd) begin
                AVL_READDATA <= rd_mux;
            end
        end
    end

    assign LED_OUT = acc;

`ifdef ACCUM_IRQ_EN
    logic irq_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            irq_en <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            if (wr && addr == ADDR_CTRL) begin
                irq_en <= AVL_WRITEDATA[1];
            end
            irq_q <= irq_en && (|edge_q);
        end
    end

    assign IRQ = irq_q;
`else
    assign irq_en = 1'b0;
    assign IRQ    = 1'b0;
`endif

endmodule
